// File: rtl/fp_pkg.sv
// fp_pkg: shared constants, class codes and helpers for the fp multiplier.
// No ports; imported by fp_mul_pipe and fp_round_pack.
package fp_pkg;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  // Result class decided in S1 and carried down to the packer.
  typedef enum logic [2:0] {
    SPC_NORM,
    SPC_ZERO,
    SPC_INF,
    SPC_QNAN,
    SPC_QNAN_INV
  } fp_spc_e;

  function automatic int fp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // {0, all-ones exponent, 1, zeros}; caller slices to its width.
  function automatic logic [63:0] fp_qnan(input int e, input int m);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < e; i++) w[m + i] = 1'b1;
    w[m - 1] = 1'b1;
    return w;
  endfunction

  // Width-agnostic classifier; subnormals fold into zero.
  function automatic fp_class_e fp_classify(
    input logic exp_zero,
    input logic exp_ones,
    input logic frac_zero,
    input logic frac_msb
  );
    fp_class_e c;
    c = CLS_NORM;
    if (exp_zero)       c = CLS_ZERO;
    else if (exp_ones) begin
      if (frac_zero)    c = CLS_INF;
      else if (frac_msb) c = CLS_QNAN;
      else              c = CLS_SNAN;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: S3 normalise, round-nearest-even and pack (combinational).
// In: i_sign, i_exp (signed E+2), i_prod (2M+2), i_spc. Out: o_word, o_flags.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int E = 8,
  parameter int M = 23
) (
  input  logic                i_sign,
  input  logic signed [E+1:0] i_exp,
  input  logic [2*M+1:0]      i_prod,
  input  fp_spc_e             i_spc,
  output logic [E+M:0]        o_word,
  output logic [3:0]          o_flags
);

  localparam logic [63:0] QNAN64 = fp_qnan(E, M);
  localparam logic [E+M:0] QNAN  = QNAN64[E+M:0];
  localparam logic signed [E+1:0] EXP_MAX  = (E+2)'((1 << E) - 1);
  localparam logic signed [E+1:0] EXP_ZERO = '0;

  logic                w_msb;
  logic [M-1:0]        w_mant;
  logic                w_guard;
  logic                w_sticky;
  logic                w_rnd;
  logic [M:0]          w_mant_sum;
  logic                w_inexact;
  logic signed [E+1:0] w_exp_fin;

  assign w_msb    = i_prod[2*M+1];
  assign w_mant   = w_msb ? i_prod[2*M -: M] : i_prod[2*M-1 -: M];
  assign w_guard  = w_msb ? i_prod[M] : i_prod[M-1];
  assign w_sticky = w_msb ? |i_prod[M-1:0] : |i_prod[M-2:0];
  assign w_rnd    = w_guard & (w_sticky | w_mant[0]);
  assign w_inexact = w_guard | w_sticky;

  // Carry out of the mantissa leaves the low M bits zero already.
  assign w_mant_sum = {1'b0, w_mant} + {{M{1'b0}}, w_rnd};

  assign w_exp_fin = i_exp
                   + $signed({{(E+1){1'b0}}, w_msb})
                   + $signed({{(E+1){1'b0}}, w_mant_sum[M]});

  always_comb begin
    o_word  = '0;
    o_flags = '0;
    unique case (i_spc)
      SPC_QNAN: o_word = QNAN;
      SPC_QNAN_INV: begin
        o_word = QNAN;
        o_flags[FLAG_INVALID] = 1'b1;
      end
      SPC_INF:  o_word = {i_sign, {E{1'b1}}, {M{1'b0}}};
      SPC_ZERO: o_word = {i_sign, {(E+M){1'b0}}};
      default: begin
        if (w_exp_fin >= EXP_MAX) begin
          o_word = {i_sign, {E{1'b1}}, {M{1'b0}}};
          o_flags[FLAG_OVERFLOW] = 1'b1;
          o_flags[FLAG_INEXACT]  = 1'b1;
        end else if (w_exp_fin <= EXP_ZERO) begin
          o_word = {i_sign, {(E+M){1'b0}}};
          o_flags[FLAG_UNDERFLOW] = 1'b1;
          o_flags[FLAG_INEXACT]   = 1'b1;
        end else begin
          o_word = {i_sign, w_exp_fin[E-1:0], w_mant_sum[M-1:0]};
          o_flags[FLAG_INEXACT] = w_inexact;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage IEEE-754 multiplier, RNE, FTZ, valid/ready stall.
// Ports: clk, rst, in_valid/in_ready, flp_a, flp_b, out_valid/out_ready, result, flags.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] flp_a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] flp_b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result,
  output logic [3:0]                             flags
);

  localparam int E = EXPONENT_WIDTH;
  localparam int M = MANTISSA_WIDTH;
  localparam int W = E + M + 1;
  localparam logic signed [E+1:0] BIAS_S = (E+2)'(fp_bias(E));

  logic                w_adv;
  logic                w_sa, w_sb;
  logic [E-1:0]        w_ea, w_eb;
  logic [M-1:0]        w_fa, w_fb;
  fp_class_e           w_cls_a, w_cls_b;
  logic                w_nan_a, w_nan_b;
  logic                w_snan_any;
  logic                w_inf_a, w_inf_b;
  logic                w_zero_a, w_zero_b;
  fp_spc_e             w_spc;
  logic signed [E+1:0] w_exp_sum;
  logic [2*M+1:0]      w_prod;
  logic [W-1:0]        w_word;
  logic [3:0]          w_flags;

  logic                r1_valid;
  logic                r1_sign;
  logic signed [E+1:0] r1_exp;
  fp_spc_e             r1_spc;
  logic [M:0]          r1_siga, r1_sigb;

  logic                r2_valid;
  logic                r2_sign;
  logic signed [E+1:0] r2_exp;
  fp_spc_e             r2_spc;
  logic [2*M+1:0]      r2_prod;

  logic                r_out_valid;
  logic [W-1:0]        r_result;
  logic [3:0]          r_flags;

  // One enable for the whole pipe; bubbles are kept, never squeezed.
  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_sa = flp_a[W-1];
  assign w_sb = flp_b[W-1];
  assign w_ea = flp_a[W-2 -: E];
  assign w_eb = flp_b[W-2 -: E];
  assign w_fa = flp_a[M-1:0];
  assign w_fb = flp_b[M-1:0];

  assign w_cls_a = fp_classify(w_ea == '0, &w_ea, w_fa == '0, w_fa[M-1]);
  assign w_cls_b = fp_classify(w_eb == '0, &w_eb, w_fb == '0, w_fb[M-1]);

  assign w_nan_a    = (w_cls_a == CLS_QNAN) || (w_cls_a == CLS_SNAN);
  assign w_nan_b    = (w_cls_b == CLS_QNAN) || (w_cls_b == CLS_SNAN);
  assign w_snan_any = (w_cls_a == CLS_SNAN) || (w_cls_b == CLS_SNAN);
  assign w_inf_a    = (w_cls_a == CLS_INF);
  assign w_inf_b    = (w_cls_b == CLS_INF);
  assign w_zero_a   = (w_cls_a == CLS_ZERO);
  assign w_zero_b   = (w_cls_b == CLS_ZERO);

  always_comb begin
    w_spc = SPC_NORM;
    priority case (1'b1)
      (w_nan_a || w_nan_b):
        w_spc = w_snan_any ? SPC_QNAN_INV : SPC_QNAN;
      ((w_inf_a && w_zero_b) || (w_zero_a && w_inf_b)):
        w_spc = SPC_QNAN_INV;
      (w_inf_a || w_inf_b):
        w_spc = SPC_INF;
      (w_zero_a || w_zero_b):
        w_spc = SPC_ZERO;
      default:
        w_spc = SPC_NORM;
    endcase
  end

  assign w_exp_sum = $signed({2'b00, w_ea})
                   + $signed({2'b00, w_eb})
                   - BIAS_S;

  assign w_prod = {{(M+1){1'b0}}, r1_siga} * {{(M+1){1'b0}}, r1_sigb};

  fp_round_pack #(
    .E (E),
    .M (M)
  ) u_round_pack (
    .i_sign  (r2_sign),
    .i_exp   (r2_exp),
    .i_prod  (r2_prod),
    .i_spc   (r2_spc),
    .o_word  (w_word),
    .o_flags (w_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_adv) begin
      r1_valid    <= in_valid;
      r2_valid    <= r1_valid;
      r_out_valid <= r2_valid;
      if (r2_valid) begin
        r_result <= w_word;
        r_flags  <= w_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_sign <= w_sa ^ w_sb;
      r1_exp  <= w_exp_sum;
      r1_spc  <= w_spc;
      r1_siga <= {1'b1, w_fa};
      r1_sigb <= {1'b1, w_fb};
      r2_sign <= r1_sign;
      r2_exp  <= r1_exp;
      r2_spc  <= r1_spc;
      r2_prod <= w_prod;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed + randomized checks of fp_mul_pipe (E=8, M=23)
// against an integer-arithmetic reference model and an ordered scoreboard.
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] flp_a;
  logic [31:0] flp_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_chk;
  int n_pass;
  int n_out;
  logic [35:0] exp_q[$];

  fp_mul_pipe #(
    .EXPONENT_WIDTH (8),
    .MANTISSA_WIDTH (23)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flp_a     (flp_a),
    .flp_b     (flp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Reference: exact significand product, rounded by remainder compare.
  function automatic logic [35:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    logic s;
    int ea, eb, e;
    longint unsigned fa, fb, p, q, rem, half;
    int sh;
    bit na, nb, sna, snb, ia, ib, za, zb, inx;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = longint'(a[22:0]);
    fb = longint'(b[22:0]);
    na  = (ea == 255) && (fa != 0);
    nb  = (eb == 255) && (fb != 0);
    sna = na && !a[22];
    snb = nb && !b[22];
    ia  = (ea == 255) && (fa == 0);
    ib  = (eb == 255) && (fb == 0);
    za  = (ea == 0);
    zb  = (eb == 0);
    s   = a[31] ^ b[31];
    if (na || nb)
      return {32'h7FC00000, (sna || snb) ? 4'b1000 : 4'b0000};
    if ((ia && zb) || (za && ib))
      return {32'h7FC00000, 4'b1000};
    if (ia || ib)
      return {s, 8'hFF, 23'd0, 4'b0000};
    if (za || zb)
      return {s, 31'd0, 4'b0000};
    p  = ((64'd1 << 23) + fa) * ((64'd1 << 23) + fb);
    e  = ea + eb - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = e + sh - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
    if (e <= 0)   return {s, 31'd0, 4'b0011};
    return {s, 8'(e), q[22:0], 3'b000, inx};
  endfunction

  function automatic logic [31:0] rnd_op();
    int k;
    logic [7:0] e;
    logic [22:0] f;
    logic s;
    k = int'($urandom_range(0, 15));
    f = 23'($urandom);
    s = 1'($urandom);
    e = 8'($urandom_range(100, 154));
    case (k)
      0: e = 8'd0;
      1: begin e = 8'hFF; f = '0; end
      2: e = 8'hFF;
      3: e = 8'($urandom_range(1, 20));
      4: e = 8'($urandom_range(230, 254));
      5: f = '1;
      default: ;
    endcase
    return {s, e, f};
  endfunction

  task automatic step(input logic iv, input logic [31:0] a,
                      input logic [31:0] b, input logic ordy,
                      output logic acc);
    @(negedge clk);
    in_valid  = iv;
    flp_a     = a;
    flp_b     = b;
    out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0)
        chk("stale", 64'(out_valid), 64'(0));
      else begin
        chk("result", 64'({result, flags}), 64'(exp_q.pop_front()));
        n_out++;
      end
    end
    acc = iv && in_ready;
    if (acc) exp_q.push_back(ref_mul(a, b));
  endtask

  task automatic dir_op(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er,
                        input logic [3:0] ef);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    flp_a     = a;
    flp_b     = b;
    out_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      #1;
    end while (!out_valid && lat < 10);
    chk({tag, "_lat"}, 64'(lat), 64'(3));
    chk({tag, "_res"}, 64'(result), 64'(er));
    chk({tag, "_flg"}, 64'(flags), 64'(ef));
  endtask

  task automatic drain(input string tag);
    logic acc;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++)
      step(1'b0, 32'd0, 32'd0, 1'b1, acc);
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic acc;
    logic [31:0] a, b;
    int sent;
    int c;
    clk = 0;
    rst = 1;
    in_valid = 0;
    flp_a = 0;
    flp_b = 0;
    out_ready = 1;
    n_chk = 0;
    n_pass = 0;
    n_out = 0;

    #12;
    chk("rst_ov", 64'(out_valid), 64'(0));
    chk("rst_res", 64'(result), 64'(0));
    chk("rst_flg", 64'(flags), 64'(0));
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_rdy", 64'(in_ready), 64'(1));

    dir_op("basic", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    dir_op("rnd",   32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    dir_op("sign",  32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000);
    dir_op("ovf",   32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    dir_op("unf",   32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    dir_op("infz",  32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000);
    dir_op("snan",  32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000);
    dir_op("sub",   32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
    dir_op("qnan",  32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0000);
    dir_op("infn",  32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    @(negedge clk);

    // 8 back-to-back ops, output stalled for cycles 4..7
    n_out = 0;
    sent = 0;
    c = 0;
    a = rnd_op();
    b = rnd_op();
    while ((sent < 8 || exp_q.size() != 0) && c < 40) begin
      step(sent < 8, a, b, !(c >= 4 && c <= 7), acc);
      if (acc) begin
        sent++;
        a = rnd_op();
        b = rnd_op();
      end
      c++;
    end
    chk("bp_sent", 64'(sent), 64'(8));
    chk("bp_recv", 64'(n_out), 64'(8));

    // random traffic with random backpressure
    a = rnd_op();
    b = rnd_op();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, a, b, ($urandom % 3) != 0, acc);
      if (acc) begin
        a = rnd_op();
        b = rnd_op();
      end
    end
    drain("drain_rand");

    // reset while operations are in flight
    for (int i = 0; i < 5; i++)
      step(1'b1, rnd_op(), rnd_op(), i != 3, acc);
    #2;
    rst = 1;
    #1;
    chk("mid_ov", 64'(out_valid), 64'(0));
    chk("mid_res", 64'(result), 64'(0));
    chk("mid_flg", 64'(flags), 64'(0));
    exp_q.delete();
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rdy", 64'(in_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'd0, 32'd0, 1'b1, acc);
      chk("mid_idle", 64'(out_valid), 64'(0));
    end
    for (int i = 0; i < 20; i++)
      step(1'b1, rnd_op(), rnd_op(), ($urandom % 2) != 0, acc);
    drain("drain_post");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
